conbus_wdarb5: RTL and testbench

CONBUS_WDARB5 -- requirements
Module: conbus_wdarb5

---
 rtl/conbus_wdarb5.sv | 90 +++++++++
 tb/tb_conbus_wdarb5.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/conbus_wdarb5.sv
// conbus_wdarb5: five-master round-robin bus arbiter with an optional ack watchdog.
// Define CONBUS_WDARB_WATCHDOG_EN to build the watchdog counter, err pulses and timeout count.
module conbus_wdarb5 #(
    parameter int TIMEOUT = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [4:0]  req,
    input  logic        ack,
    output logic [2:0]  gnt,
    output logic [4:0]  err,
    output logic [15:0] timeouts
);

    logic [2:0] gnt_q, gnt_d;
    logic       cur_req;
    logic       fire;

    // Nearest requester after cur in round-robin order; returns cur when nobody else asks.
    function automatic logic [2:0] rr_next(input logic [2:0] cur, input logic [4:0] r);
        logic [3:0] sum;
        logic [2:0] idx;
        rr_next = cur;
        for (int k = 4; k >= 1; k--) begin
            sum = {1'b0, cur} + 4'(k);
            idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (r[idx]) rr_next = idx;
        end
    endfunction

    assign cur_req = req[gnt_q];

    always_comb begin
        // NOTE: default first so every path assigns gnt_d and no latch is inferred.
        gnt_d = gnt_q;
        if (!cur_req || fire) gnt_d = rr_next(gnt_q, req);
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
        if (sys_rst) gnt_q <= 3'd0;
        else         gnt_q <= gnt_d;
    end

    assign gnt = gnt_q;

`ifdef CONBUS_WDARB_WATCHDOG_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic [4:0]  err_q, err_d;
    logic [15:0] timeouts_q, timeouts_d;

    // ack in the firing cycle suppresses the fire.
    assign fire = cur_req && !ack && (wd_cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        err_d      = 5'd0;
        timeouts_d = timeouts_q;
        wd_cnt_d   = wd_cnt_q + 16'd1;
        if (fire) begin
            err_d = 5'b00001 << gnt_q;
            if (timeouts_q != 16'hFFFF) timeouts_d = timeouts_q + 16'd1;
        end
        // A grant change only happens on a req drop or a fire, so this also covers it.
        if (ack || !cur_req || fire) wd_cnt_d = 16'd0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wd_cnt_q   <= 16'd0;
            err_q      <= 5'd0;
            timeouts_q <= 16'd0;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            err_q      <= err_d;
            timeouts_q <= timeouts_d;
        end
    end

    assign err      = err_q;
    assign timeouts = timeouts_q;
`else
    logic unused_cfg;

    assign fire       = 1'b0;
    assign err        = 5'd0;
    assign timeouts   = 16'd0;
    assign unused_cfg = ack & (TIMEOUT > 1);
`endif

endmodule

// File: tb/tb_conbus_wdarb5.sv
// Self-checking bench for conbus_wdarb5: a behavioural model feeds a scoreboard of per-cycle expectations.
module tb_conbus_wdarb5;

    localparam int TO = 8;
`ifdef CONBUS_WDARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        sys_clk;
    logic        sys_rst;
    logic [4:0]  req;
    logic        ack;
    logic [2:0]  gnt;
    logic [4:0]  err;
    logic [15:0] timeouts;

    conbus_wdarb5 #(.TIMEOUT(TO)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req      (req),
        .ack      (ack),
        .gnt      (gnt),
        .err      (err),
        .timeouts (timeouts)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [2:0]  gnt;
        logic [4:0]  err;
        logic [15:0] to;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int          m_gnt;
    int          m_cnt;
    logic [4:0]  m_err;
    logic [15:0] m_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic [4:0] rq, input logic a);
        bit fire;
        int n_gnt;
        if (r) begin
            m_gnt = 0; m_cnt = 0; m_err = 5'd0; m_to = 16'd0;
        end else begin
            fire  = WD && rq[m_gnt] && !a && (m_cnt == TO - 1);
            n_gnt = m_gnt;
            if (!rq[m_gnt] || fire) begin
                for (int d = 1; d < 5; d++) begin
                    if (rq[(m_gnt + d) % 5]) begin
                        n_gnt = (m_gnt + d) % 5;
                        break;
                    end
                end
            end
            m_err = fire ? (5'b00001 << m_gnt) : 5'd0;
            if (fire && m_to != 16'hFFFF) m_to = m_to + 16'd1;
            if (a || !rq[m_gnt] || fire || n_gnt != m_gnt) m_cnt = 0;
            else                                           m_cnt = m_cnt + 1;
            m_gnt = n_gnt;
        end
    endtask

    task automatic step(input logic r, input logic [4:0] rq, input logic a);
        exp_t e;
        sys_rst = r;
        req     = rq;
        ack     = a;
        model(r, rq, a);
        e.gnt = 3'(m_gnt);
        e.err = m_err;
        e.to  = m_to;
        sb_q.push_back(e);
        @(posedge sys_clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("gnt", 32'(gnt), 32'(e.gnt));
            check("err", 32'(err), 32'(e.err));
            check("timeouts", 32'(timeouts), 32'(e.to));
            check("err_onehot0", 32'($onehot0(err)), 32'd1);
        end
    endtask

    initial begin
        int first_err;
        int err_seen;
        logic [4:0] rq;
        sys_rst = 1'b1;
        req     = 5'd0;
        ack     = 1'b0;
        #1;

        // Reset then idle bus.
        step(1'b1, 5'd0, 1'b0);
        step(1'b1, 5'd0, 1'b0);
        check("reset_gnt", 32'(gnt), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 5'd0, 1'b0);
        check("idle_gnt", 32'(gnt), 32'd0);

        // Round-robin hand-off 1 -> 2 -> 4 -> 1.
        step(1'b0, 5'b10110, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 5'b10110, i[0]);
        check("rr_hold1", 32'(gnt), 32'd1);
        step(1'b0, 5'b10100, 1'b1);
        check("rr_to2", 32'(gnt), 32'd2);
        step(1'b0, 5'b10000, 1'b1);
        check("rr_to4", 32'(gnt), 32'd4);
        step(1'b0, 5'b00010, 1'b1);
        check("rr_to1", 32'(gnt), 32'd1);

        // Lone master 3 with no ack.
        step(1'b1, 5'd0, 1'b0);
        step(1'b0, 5'b01000, 1'b0);
        first_err = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 5'b01000, 1'b0);
            if (err != 5'd0 && first_err == 0) first_err = k;
        end
        check("lone_err_cycle", 32'(first_err), WD ? 32'd8 : 32'd0);
        check("lone_gnt", 32'(gnt), 32'd3);
        check("lone_timeouts", 32'(timeouts), WD ? 32'd1 : 32'd0);

        // Masters 0 and 2: timeout moves the grant.
        step(1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 5'b00101, 1'b0);
        check("fire0_err", 32'(err), WD ? 32'h01 : 32'h00);
        check("fire0_gnt", 32'(gnt), WD ? 32'd2 : 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 5'b00101, 1'b0);
        check("fire2_err", 32'(err), WD ? 32'h04 : 32'h00);
        check("fire2_gnt", 32'(gnt), WD ? 32'd0 : 32'd0);

        // Ack every 7th cycle keeps the watchdog quiet.
        step(1'b1, 5'd0, 1'b0);
        err_seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 5'b01000, (i % 7) == 6);
            if (err != 5'd0) err_seen++;
        end
        check("ack7_err", 32'(err_seen), 32'd0);
        check("ack7_gnt", 32'(gnt), 32'd3);

        // Reset mid-transfer aborts without err.
        step(1'b0, 5'b01000, 1'b0);
        step(1'b1, 5'b01000, 1'b0);
        check("abort_gnt", 32'(gnt), 32'd0);
        step(1'b0, 5'b01000, 1'b0);
        check("abort_regrant", 32'(gnt), 32'd3);

        // Random traffic with slowly changing requests and sparse acks.
        rq = 5'b10101;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rq = 5'($urandom_range(0, 31));
            step(1'b0, rq, $urandom_range(0, 11) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
